// File: rtl/bin_to_ascii_dec_if.sv
// Handshake and result bundle between a counter source and the decimal ASCII converter.
interface bin_to_ascii_dec_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 16
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  valid;
  logic                  overflow;
  logic [8*DIGITS-1:0]   ascii_out;

  modport master (output start, value, input busy, valid, overflow, ascii_out);
  modport slave  (input start, value, output busy, valid, overflow, ascii_out);
endinterface

// File: rtl/bin_to_ascii_dec.sv
// Sequential double-dabble binary-to-decimal converter producing a fixed-width ASCII field
// for one LCD line, with justification, leading-zero blanking and overflow marking.
module bin_to_ascii_dec #(
  parameter int         WIDTH         = 32,
  parameter int         DIGITS        = 16,
  parameter bit         BLANK_LEADING = 1'b1,
  parameter bit         RIGHT_JUSTIFY = 1'b1,
  parameter logic [7:0] PAD_CHAR      = 8'h20
) (
  input logic          clk,
  input logic          rst,
  bin_to_ascii_dec_if.slave bus
);
  localparam int BCD_DIGITS = (WIDTH * 3) / 10 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SH_W       = BCD_W + WIDTH;
  localparam int CNT_W      = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_FORMAT  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SH_W-1:0]     sh_reg;
  logic [SH_W-1:0]     sh_next;
  logic [BCD_W-1:0]    bcd;
  int                  n_sig;
  logic [8*DIGITS-1:0] fmt_ascii;
  logic                fmt_ovf;
  logic                busy_r;
  logic                valid_r;
  logic                ovf_r;
  logic [8*DIGITS-1:0] ascii_r;

  assign bcd = sh_reg[SH_W-1 -: BCD_W];

  // Safe digit lookup; positions past the BCD register read as zero.
  function automatic logic [3:0] dig(input logic [BCD_W-1:0] b, input int idx);
    dig = 4'h0;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (i == idx) dig = b[4*i +: 4];
  endfunction

  always_comb begin
    sh_next = sh_reg;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (sh_next[WIDTH+4*i +: 4] >= 4'd5)
        sh_next[WIDTH+4*i +: 4] = sh_next[WIDTH+4*i +: 4] + 4'd3;
    sh_next = sh_next << 1;
  end

  always_comb begin
    n_sig = 1;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (bcd[4*i +: 4] != 4'h0) n_sig = i + 1;
  end

  // Character p counts from the rightmost position of the field.
  always_comb begin
    fmt_ascii = {DIGITS{PAD_CHAR}};
    fmt_ovf   = (n_sig > DIGITS);
    for (int p = 0; p < DIGITS; p++) begin
      if (fmt_ovf)
        fmt_ascii[8*p +: 8] = 8'h2A;
      else if (RIGHT_JUSTIFY) begin
        if (p < n_sig)           fmt_ascii[8*p +: 8] = {4'h3, dig(bcd, p)};
        else if (!BLANK_LEADING) fmt_ascii[8*p +: 8] = 8'h30;
      end else if ((DIGITS - 1 - p) < n_sig)
        fmt_ascii[8*p +: 8] = {4'h3, dig(bcd, n_sig - 1 - (DIGITS - 1 - p))};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      sh_reg  <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
      ascii_r <= {DIGITS{PAD_CHAR}};
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) begin
          sh_reg  <= {{BCD_W{1'b0}}, bus.value};
          bit_cnt <= '0;
          busy_r  <= 1'b1;
          valid_r <= 1'b0;
          state   <= S_CONVERT;
        end
        S_CONVERT: begin
          sh_reg <= sh_next;
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            bit_cnt <= '0;
            state   <= S_FORMAT;
          end else
            bit_cnt <= bit_cnt + 1'b1;
        end
        S_FORMAT: begin
          ascii_r <= fmt_ascii;
          ovf_r   <= fmt_ovf;
          busy_r  <= 1'b0;
          valid_r <= 1'b1;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.valid     = valid_r;
  assign bus.overflow  = ovf_r;
  assign bus.ascii_out = ascii_r;
endmodule
